// File: rtl/count_bcd_display.sv
// Converts a 16-bit count into five active-low seven-segment digit drives,
// decimal via an iterative double-dabble engine or raw hex nibbles.
module count_bcd_display #(
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] value,
   input  logic        hex_mode,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic        busy,
   output logic        update
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_LOAD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [15:0] r_snap_val;
   logic        r_snap_mode;
   logic        r_force;
   logic [35:0] r_shift;
   logic [3:0]  r_cnt;
   logic [6:0]  r_hex [0:4];
   logic        r_busy;
   logic        r_update;

   logic        w_trigger;
   logic        w_start;
   logic        w_iter;
   logic        w_load;
   logic [3:0]  w_adj [0:3];
   logic [2:0]  w_adj_top;
   logic [35:0] w_shift_next;
   logic [3:0]  w_digit [0:4];
   logic [4:0]  w_nz;
   logic [4:0]  w_lit;
   logic [4:0]  w_blank;
   logic [6:0]  w_seg [0:4];

   function automatic logic [6:0] f_seg7(input logic [3:0] i_d);
      logic [6:0] w_s;
      case (i_d)
         4'h0: w_s = 7'h40;
         4'h1: w_s = 7'h79;
         4'h2: w_s = 7'h24;
         4'h3: w_s = 7'h30;
         4'h4: w_s = 7'h19;
         4'h5: w_s = 7'h12;
         4'h6: w_s = 7'h02;
         4'h7: w_s = 7'h78;
         4'h8: w_s = 7'h00;
         4'h9: w_s = 7'h10;
         4'hA: w_s = 7'h08;
         4'hB: w_s = 7'h03;
         4'hC: w_s = 7'h46;
         4'hD: w_s = 7'h21;
         4'hE: w_s = 7'h06;
         default: w_s = 7'h0E;
      endcase
      return w_s;
   endfunction

   assign w_trigger = (value != r_snap_val) || (hex_mode != r_snap_mode) || r_force;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_trigger) w_state_next = S_CONV;
         S_CONV: if (r_cnt == 4'd15) w_state_next = S_LOAD;
         S_LOAD: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Control decode
   always_comb begin
      w_start = 1'b0;
      w_iter  = 1'b0;
      w_load  = 1'b0;
      case (r_state)
         S_IDLE: w_start = w_trigger;
         S_CONV: w_iter  = 1'b1;
         S_LOAD: w_load  = 1'b1;
         default: ;
      endcase
   end

   // Add-3 on each BCD nibble >= 5; the top digit never exceeds 4 before its
   // final shift, so only its low three bits carry into the shifted result.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_adj
         assign w_adj[gi] = (r_shift[16+4*gi +: 4] >= 4'd5) ? r_shift[16+4*gi +: 4] + 4'd3
                                                            : r_shift[16+4*gi +: 4];
      end
   endgenerate
   assign w_adj_top    = (r_shift[35:32] >= 4'd5) ? r_shift[34:32] + 3'd3 : r_shift[34:32];
   assign w_shift_next = {w_adj_top, w_adj[3], w_adj[2], w_adj[1], w_adj[0], r_shift[15:0], 1'b0};

   generate
      for (gi = 0; gi < 5; gi++) begin : g_digit
         if (gi == 4) begin : g_top
            assign w_digit[gi] = r_snap_mode ? 4'h0 : r_shift[16+4*gi +: 4];
            assign w_lit[gi]   = w_nz[gi];
         end else begin : g_low
            assign w_digit[gi] = r_snap_mode ? r_snap_val[4*gi +: 4] : r_shift[16+4*gi +: 4];
            assign w_lit[gi]   = w_nz[gi] | w_lit[gi+1];
         end
         assign w_nz[gi]    = |w_digit[gi];
         assign w_blank[gi] = (BLANK_LZ && (gi != 0) && !w_lit[gi]) || ((gi == 4) && r_snap_mode);
         assign w_seg[gi]   = w_blank[gi] ? 7'h7F : f_seg7(w_digit[gi]);
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_snap_val  <= 16'd0;
         r_snap_mode <= 1'b0;
         r_force     <= 1'b1;
         r_shift     <= 36'd0;
         r_cnt       <= 4'd0;
         r_busy      <= 1'b0;
         r_update    <= 1'b0;
         for (int i = 0; i < 5; i++) r_hex[i] <= 7'h7F;
      end else begin
         r_update <= w_load;
         if (w_start) begin
            r_snap_val  <= value;
            r_snap_mode <= hex_mode;
            r_shift     <= {20'd0, value};
            r_cnt       <= 4'd0;
            r_force     <= 1'b0;
            r_busy      <= 1'b1;
         end else if (w_iter) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 4'd1;
         end
         if (w_load) begin
            r_busy <= 1'b0;
            for (int i = 0; i < 5; i++) r_hex[i] <= w_seg[i];
         end
      end
   end

   assign hex0   = r_hex[0];
   assign hex1   = r_hex[1];
   assign hex2   = r_hex[2];
   assign hex3   = r_hex[3];
   assign hex4   = r_hex[4];
   assign busy   = r_busy;
   assign update = r_update;

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed bench for count_bcd_display: two builds (leading-zero blanking on/off)
// share the same stimulus; expected segment codes are hand-computed.
module tb_count_bcd_display;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] value = 16'd0;
   logic        hex_mode = 1'b0;

   logic [6:0]  hex0, hex1, hex2, hex3, hex4;
   logic        busy, update;
   logic [6:0]  nb_hex0, nb_hex1, nb_hex2, nb_hex3, nb_hex4;
   logic        nb_busy, nb_update;

   int checks = 0;
   int errors = 0;
   int lat, busy_cyc, upd_cnt;

   always #5 clk = ~clk;

   count_bcd_display #(.BLANK_LZ(1'b1)) u_dut (
      .clk(clk), .reset_n(reset_n), .value(value), .hex_mode(hex_mode),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
      .busy(busy), .update(update)
   );

   count_bcd_display #(.BLANK_LZ(1'b0)) u_dut_nb (
      .clk(clk), .reset_n(reset_n), .value(value), .hex_mode(hex_mode),
      .hex0(nb_hex0), .hex1(nb_hex1), .hex2(nb_hex2), .hex3(nb_hex3), .hex4(nb_hex4),
      .busy(nb_busy), .update(nb_update)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_disp(input string tag, input logic [6:0] e4, input logic [6:0] e3,
                             input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
      check_eq({tag, "_hex4"}, 32'(hex4), 32'(e4));
      check_eq({tag, "_hex3"}, 32'(hex3), 32'(e3));
      check_eq({tag, "_hex2"}, 32'(hex2), 32'(e2));
      check_eq({tag, "_hex1"}, 32'(hex1), 32'(e1));
      check_eq({tag, "_hex0"}, 32'(hex0), 32'(e0));
   endtask

   // Counts sample points (1 ns after each rising edge) until update is seen.
   task automatic run_conv(input string tag, output int o_lat, output int o_busy);
      o_lat  = 0;
      o_busy = 0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (busy) o_busy++;
         if (update) begin
            o_lat = n;
            break;
         end
      end
      $display("conv %s value=%0d mode=%0d lat=%0d busy_cycles=%0d disp=%h %h %h %h %h",
               tag, value, hex_mode, o_lat, o_busy, hex4, hex3, hex2, hex1, hex0);
   endtask

   initial begin
      // Reset state
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_disp("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_update", 32'(update), 32'd0);

      // Forced conversion of 0 after release
      reset_n = 1'b1;
      run_conv("zero", lat, busy_cyc);
      check_eq("zero_lat", lat, 18);
      check_disp("zero", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
      check_eq("zero_nb_hex4", 32'(nb_hex4), 32'h40);
      check_eq("zero_nb_hex1", 32'(nb_hex1), 32'h40);

      // Maximum value
      value = 16'd65535;
      run_conv("max", lat, busy_cyc);
      check_eq("max_lat", lat, 18);
      check_eq("max_busy_cycles", busy_cyc, 17);
      check_disp("max", 7'h02, 7'h12, 7'h12, 7'h30, 7'h12);
      @(posedge clk);
      #1;
      check_eq("update_pulse_width", 32'(update), 32'd0);

      // No input change: no further conversion
      upd_cnt = 0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk);
         #1;
         if (update || busy) upd_cnt++;
      end
      check_eq("idle_quiet", upd_cnt, 0);

      // Leading-zero blanking on and off
      value = 16'd1234;
      run_conv("1234", lat, busy_cyc);
      check_disp("1234", 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19);
      check_eq("1234_nb_hex4", 32'(nb_hex4), 32'h40);
      check_eq("1234_nb_hex3", 32'(nb_hex3), 32'h79);

      // 0xBEEF decimal (48879), then mode toggle alone retriggers
      value = 16'hBEEF;
      run_conv("beef_dec", lat, busy_cyc);
      check_disp("beef_dec", 7'h19, 7'h00, 7'h00, 7'h78, 7'h10);
      hex_mode = 1'b1;
      run_conv("beef_hex", lat, busy_cyc);
      check_eq("mode_toggle_lat", lat, 18);
      check_disp("beef_hex", 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E);
      check_eq("beef_hex_nb_hex4", 32'(nb_hex4), 32'h7F);

      // Value change during CONV: in-flight conversion keeps the snapshot
      hex_mode = 1'b0;
      value    = 16'd100;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         #1;
      end
      value = 16'd200;
      run_conv("100", lat, busy_cyc);
      check_eq("mid_change_lat", lat + 6, 18);
      check_disp("100", 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40);
      run_conv("200", lat, busy_cyc);
      check_eq("back_to_back_spacing", lat, 18);
      check_disp("200", 7'h7F, 7'h7F, 7'h24, 7'h40, 7'h40);

      // Asynchronous reset in CONV cycle 8
      value = 16'd4321;
      for (int n = 0; n < 9; n++) begin
         @(posedge clk);
         #1;
      end
      reset_n = 1'b0;
      #1;
      check_disp("abort", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_update", 32'(update), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      run_conv("4321", lat, busy_cyc);
      check_eq("after_reset_lat", lat, 18);
      check_disp("4321", 7'h7F, 7'h19, 7'h30, 7'h24, 7'h79);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
